// File: rtl/glitc_threshold_servo.sv
// glitc_threshold_servo: snapshot-driven threshold servo for a dual trigger scaler; optional deadband via SERVO_DEADBAND_EN
module glitc_threshold_servo #(
  parameter int THR_BITS = 16,
  parameter int GAIN_SHIFT = 4,
  parameter int MAX_STEP = 64,
  parameter int DEADBAND = 8,
  parameter logic [THR_BITS-1:0] THR_RESET = {1'b1, {(THR_BITS-1){1'b0}}}
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                scaler_valid_i,
  input  logic [23:0]         upper_scaler_i,
  input  logic [23:0]         lower_scaler_i,
  input  logic [22:0]         goal_i,
  input  logic                thr_load_i,
  input  logic                thr_load_sel_i,
  input  logic [THR_BITS-1:0] thr_load_value_i,
  output logic [THR_BITS-1:0] upper_threshold_o,
  output logic [THR_BITS-1:0] lower_threshold_o,
  output logic                threshold_update_o,
  output logic                busy_o
);
  localparam logic [2:0] IDLE = 3'd0, CAPTURE = 3'd1, CALC_U = 3'd2, CALC_L = 3'd3, APPLY = 3'd4;
  localparam logic signed [23:0] MS = 24'(MAX_STEP);
  localparam logic signed [23:0] TMAX = 24'((1 << THR_BITS) - 1);
`ifdef SERVO_DEADBAND_EN
  localparam logic signed [23:0] DB = 24'(DEADBAND);
`else
  logic unused_db;
  assign unused_db = ^DEADBAND;
`endif
  logic [2:0] state_q, state_d;
  logic [23:0] up_q, up_d, lo_q, lo_d;
  logic [22:0] goal_q, goal_d;
  logic signed [23:0] su_q, su_d, sl_q, sl_d;
  logic [THR_BITS-1:0] thr_u_q, thr_u_d, thr_l_q, thr_l_d;
  logic upd_q, upd_d;

  function automatic logic signed [23:0] step_of(input logic [23:0] s, input logic [22:0] g);
    logic signed [23:0] err, raw;
    logic db;
    err = $signed({1'b0, s[22:0]} - {1'b0, g});
    raw = err >>> GAIN_SHIFT;
`ifdef SERVO_DEADBAND_EN
    db = err <= DB && err >= -DB;
`else
    db = 1'b0;
`endif
    return s[23] ? MS : db ? '0 : raw > MS ? MS : raw < -MS ? -MS : raw;
  endfunction

  function automatic logic [THR_BITS-1:0] sat_add(input logic [THR_BITS-1:0] t, input logic signed [23:0] st);
    logic signed [23:0] s;
    s = $signed(24'(t)) + st;
    return s < 0 ? '0 : s > TMAX ? '1 : s[THR_BITS-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    up_d = up_q;
    lo_d = lo_q;
    goal_d = goal_q;
    su_d = su_q;
    sl_d = sl_q;
    thr_u_d = thr_u_q;
    thr_l_d = thr_l_q;
    upd_d = 1'b0;
    if (thr_load_i) begin
      state_d = IDLE;
      thr_u_d = thr_load_sel_i ? thr_load_value_i : thr_u_q;
      thr_l_d = thr_load_sel_i ? thr_l_q : thr_load_value_i;
      upd_d = 1'b1;
    end else if (state_q == IDLE) begin
      state_d = scaler_valid_i && enable_i ? CAPTURE : IDLE;
      up_d = upper_scaler_i;
      lo_d = lower_scaler_i;
      goal_d = goal_i;
    end else if (state_q == CAPTURE) begin
      state_d = CALC_U;
    end else if (state_q == CALC_U) begin
      su_d = step_of(up_q, goal_q);
      state_d = CALC_L;
    end else if (state_q == CALC_L) begin
      sl_d = step_of(lo_q, goal_q);
      state_d = APPLY;
    end else if (state_q == APPLY) begin
      thr_u_d = sat_add(thr_u_q, su_q);
      thr_l_d = sat_add(thr_l_q, sl_q);
      upd_d = thr_u_d != thr_u_q || thr_l_d != thr_l_q;
      state_d = IDLE;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      up_q <= '0;
      lo_q <= '0;
      goal_q <= '0;
      su_q <= '0;
      sl_q <= '0;
      thr_u_q <= THR_RESET;
      thr_l_q <= THR_RESET;
      upd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      up_q <= up_d;
      lo_q <= lo_d;
      goal_q <= goal_d;
      su_q <= su_d;
      sl_q <= sl_d;
      thr_u_q <= thr_u_d;
      thr_l_q <= thr_l_d;
      upd_q <= upd_d;
    end
  end

  assign upper_threshold_o = thr_u_q;
  assign lower_threshold_o = thr_l_q;
  assign threshold_update_o = upd_q;
  assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_glitc_threshold_servo.sv
// tb_glitc_threshold_servo: scoreboard bench for glitc_threshold_servo
module tb_glitc_threshold_servo;
  logic clk = 1'b0;
  logic rst, enable, valid, load, load_sel;
  logic [23:0] up_s, lo_s;
  logic [22:0] goal;
  logic [15:0] load_val, up_thr, lo_thr;
  logic upd, busy;
  logic [31:0] exp_q[$];
  logic [31:0] e;
  int tests = 0;
  int fails = 0;
`ifdef SERVO_DEADBAND_EN
  localparam logic [15:0] LO_SMALL = 16'h8000;
`else
  localparam logic [15:0] LO_SMALL = 16'h7FFF;
`endif

  glitc_threshold_servo dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .scaler_valid_i(valid),
    .upper_scaler_i(up_s), .lower_scaler_i(lo_s), .goal_i(goal),
    .thr_load_i(load), .thr_load_sel_i(load_sel), .thr_load_value_i(load_val),
    .upper_threshold_o(up_thr), .lower_threshold_o(lo_thr),
    .threshold_update_o(upd), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (upd) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got %h/%h expected no pulse", up_thr, lo_thr);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_thresholds", {up_thr, lo_thr}, e);
      end
    end
  end

  task automatic strobe(input logic [23:0] u, input logic [23:0] l, input logic [22:0] g);
    up_s = u;
    lo_s = l;
    goal = g;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic do_load(input logic sel, input logic [15:0] v, input logic [31:0] exp);
    exp_q.push_back(exp);
    load_sel = sel;
    load_val = v;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_within_bound", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; valid = 1'b0; load = 1'b0; load_sel = 1'b0;
    up_s = '0; lo_s = '0; goal = '0; load_val = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_thresholds", {up_thr, lo_thr}, 32'h8000_8000);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_update", {31'd0, upd}, 32'd0);
    exp_q.push_back(32'h800A_7FCE);
    strobe(24'd1160, 24'd200, 23'd1000);
    chk("busy_after_strobe", {31'd0, busy}, 32'd1);
    strobe(24'd0, 24'd0, 23'd5000);
    repeat (2) @(posedge clk);
    #1;
    chk("no_early_pulse", {31'd0, upd}, 32'd0);
    chk("no_early_update", {up_thr, lo_thr}, 32'h8000_8000);
    @(posedge clk);
    #1;
    chk("pulse_at_latency4", {31'd0, upd}, 32'd1);
    settle();
    chk("ignored_strobe_result", {up_thr, lo_thr}, 32'h800A_7FCE);
    do_load(1'b1, 16'hFFF0, 32'hFFF0_7FCE);
    do_load(1'b0, 16'h0010, 32'hFFF0_0010);
    exp_q.push_back(32'hFFFF_0010);
    strobe(24'd1000000, 24'd0, 23'd0);
    settle();
    exp_q.push_back(32'hFFFF_0000);
    strobe(24'd1000000, 24'd0, 23'd1000000);
    settle();
    do_load(1'b1, 16'h8000, 32'h8000_0000);
    do_load(1'b0, 16'h8000, 32'h8000_8000);
    exp_q.push_back(32'h8040_8000);
    strobe(24'h800000, 24'h7FFFFF, 23'h7FFFFF);
    settle();
    strobe(24'd1160, 24'd200, 23'd1000);
    do_load(1'b1, 16'h1234, 32'h1234_8000);
    chk("abort_to_idle", {31'd0, busy}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_result", {up_thr, lo_thr}, 32'h1234_8000);
    if (LO_SMALL != 16'h8000) exp_q.push_back({16'h1234, LO_SMALL});
    strobe(24'd1007, 24'd999, 23'd1000);
    settle();
    chk("small_error_result", {up_thr, lo_thr}, {16'h1234, LO_SMALL});
    enable = 1'b0;
    strobe(24'd2000, 24'd2000, 23'd0);
    chk("disabled_strobe_ignored", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    exp_q.push_back({16'h1235, LO_SMALL});
    strobe(24'd1016, 24'd1000, 23'd1000);
    enable = 1'b0;
    settle();
    enable = 1'b1;
    chk("enable_drop_completes", {up_thr, lo_thr}, {16'h1235, LO_SMALL});
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
